// File: rtl/note_tone_generator.sv
// note_tone_generator: highest-key-priority 50% duty square-wave tone from per-note full-period counts.
// Optional macro TONE_RELEASE_EN lets a high half finish on key release instead of cutting it short.
module note_tone_generator #(
  parameter int DIV_W = 18,
  parameter int NUM_KEYS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [DIV_W-1:0]    div0,
  input  logic [DIV_W-1:0]    div1,
  input  logic [DIV_W-1:0]    div2,
  input  logic [DIV_W-1:0]    div3,
  input  logic [DIV_W-1:0]    div4,
  input  logic [DIV_W-1:0]    div5,
  input  logic [DIV_W-1:0]    div6,
  input  logic [DIV_W-1:0]    div7,
  input  logic [DIV_W-1:0]    div8,
  input  logic [DIV_W-1:0]    div9,
  input  logic [DIV_W-1:0]    div10,
  input  logic [DIV_W-1:0]    div11,
  output logic                tone_out,
  output logic                note_valid,
  output logic [3:0]          note_idx
);
`ifdef TONE_RELEASE_EN
  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif
  state_t state;
  logic [DIV_W-1:0] divs [12];
  logic [DIV_W-1:0] counter, half_reg, half_sel, half_cur;
  logic [3:0] sel;
  logic sel_valid, wrap;
  function automatic logic [DIV_W-1:0] half_of(input logic [DIV_W-1:0] d);
    return (d >> 1) == '0 ? DIV_W'(1) : d >> 1;
  endfunction
  assign divs = '{div0, div1, div2, div3, div4, div5, div6, div7, div8, div9, div10, div11};
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_KEYS; i++) sel = keys[i] ? 4'(i) : sel;
  end
  assign sel_valid = |keys;
  assign half_sel = half_of(divs[sel]);
  assign half_cur = half_of(divs[note_idx]);
  assign wrap = counter == half_reg - 1'b1;
  // half_reg is only reloaded at a half-period edge, so octave changes never glitch the output
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tone_out <= 1'b0;
      note_valid <= 1'b0;
      note_idx <= '0;
      counter <= '0;
      half_reg <= '0;
    end else if (sel_valid && (state != PLAY || sel != note_idx)) begin
      state <= PLAY;
      note_idx <= sel;
      note_valid <= 1'b1;
      half_reg <= half_sel;
      counter <= '0;
      tone_out <= 1'b0;
    end else if (state == IDLE || !sel_valid) begin
`ifdef TONE_RELEASE_EN
      if (state != IDLE && tone_out && !wrap) begin
        state <= RELEASE;
        counter <= counter + 1'b1;
      end else
`endif
      begin
        state <= IDLE;
        tone_out <= 1'b0;
        note_valid <= 1'b0;
        note_idx <= '0;
        counter <= '0;
      end
    end else if (wrap) begin
      tone_out <= ~tone_out;
      counter <= '0;
      half_reg <= half_cur;
    end else
      counter <= counter + 1'b1;
endmodule

// File: doc/note_tone_generator.md
Name: note_tone_generator

Overview:
- Sits directly downstream of the octave-scaled frequency divider.
- Takes the twelve per-note full-period counts (div0..div11, in 10 MHz clock cycles) and a 12-bit key vector.
- Selects the active note and produces a 50%-duty square-wave tone on a single output bit that drives the audio/PWM output stage.
- Picks up divisor changes (octave up/down) only at half-period boundaries, so the output never glitches.

Parameters:
- DIV_W, 18: width of each divisor input and of the internal half-period counter.
- NUM_KEYS, 12: number of key/note inputs; fixed at 12 for this design.

Ports:
- clk  in  1  system clock, 10 MHz
- rst  in  1  synchronous reset, active-high
- keys  in  12  key pressed flags; bit i selects note i (0=C .. 11=B)
- div0..div11  in  18 each  full-period count for note i at the current octave
- tone_out  out  1  square-wave tone
- note_valid  out  1  high while a note is sounding
- note_idx  out  4  index of the sounding note; 0 when idle

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, tone_out=0, note_valid=0, note_idx=0, counter=0, half_reg=0. Reset mid-tone aborts immediately, with no release phase.

Key selection:
- Combinational priority encoder; the highest set bit of keys wins (highest pitch).
- sel_valid = |keys.

Half-period computation:
- half = div[sel] >> 1, truncating.
- If half == 0, use 1 instead (clamp).
- half_reg holds the current half-period length.

States:
- IDLE
  - tone_out=0, counter=0.
  - If sel_valid: go to PLAY next cycle; note_idx<=sel, note_valid<=1, half_reg<=half(sel), counter<=0, tone_out<=0.
- PLAY, normal counting:
  - counter increments each cycle.
  - When counter == half_reg-1: tone_out toggles, counter<=0, half_reg<=half(note_idx) re-sampled from the current divN.
  - An octave change therefore takes effect at the next edge, never mid-half.
- PLAY, key changes:
  - If sel_valid and sel != note_idx: restart on the next cycle. note_idx<=sel, counter<=0, tone_out<=0, half_reg<=half(sel). Restart takes priority over a same-cycle toggle.
  - If sel == note_idx: keep playing, no restart, even if other lower keys change.
- PLAY, release:
  - If !sel_valid: go to IDLE next cycle; tone_out<=0, note_valid<=0, note_idx<=0 (behaviour without the optional feature).

Latency and timing:
- keys asserted at edge N: note_valid=1 after edge N+1.
- First rising tone_out after edge N+1+half_reg.
- Full period = 2*half_reg cycles; odd divisors lose 1 cycle per period.

Counter width:
- Counter is DIV_W bits and never exceeds half_reg-1, so there is no wrap-around.

Optional Feature:
- Macro: TONE_RELEASE_EN
- Defined: key release in PLAY enters a RELEASE state instead of IDLE.
  - If tone_out=0 at release: go to IDLE immediately (next cycle).
  - If tone_out=1: counter keeps running to half_reg-1, then tone_out<=0 and go to IDLE. This avoids a truncated high pulse.
  - note_valid stays 1 during RELEASE.
  - A new key in RELEASE restarts exactly as from IDLE (counter=0, tone_out=0).
  - rst still aborts RELEASE.
- Undefined: release goes straight to IDLE as described in Behaviour. No RELEASE state is synthesised.

Test Plan:
- Reset, then keys=0 for 20 cycles -> tone_out=0, note_valid=0, note_idx=0 throughout.
- div5=10, keys=12'h020 -> note_valid=1, note_idx=5 one cycle later. tone_out then toggles every 5 cycles (period 10) for at least 4 periods.
- keys=12'h021 (C and F), div0=20, div5=10 -> note_idx=5, half=5. Then drop bit5 (keys=12'h001) -> next cycle note_idx=0, tone_out=0, counter restarted, period 20.
- div5=10 during PLAY, change div5 to 6 mid-half -> the current half still lasts 5 cycles, subsequent halves last 3. Also drive div5=1 -> half clamps to 1, tone_out toggles every cycle.
- div3=40, rst pulsed 1 cycle while tone_out=1 -> all outputs 0 after that edge. With keys still held, PLAY restarts 1 cycle after rst deasserts.
- (TONE_RELEASE_EN) div2=16, release keys 2 cycles into a high half -> tone_out stays 1 for 6 more cycles, then 0, note_valid falls with it. Release during a low half -> idle next cycle.
